// File: rtl/fcb_cfg_seq.sv
// Configuration sequencer: programs the 32-lane CCFF chain from APB words and reads it back,
// generating checksum enables. Optional macro FCB_CFG_SEQ_RB_RESTORE_EN makes readback rotate.
module fcb_cfg_seq #(
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned CNT_W     = 11
) (
    input  logic             FCB_CLK,
    input  logic             fcb_reg_rstn,
    input  logic [1:0]       CSR_SEQ_cfgcmd,
    input  logic             CSR_SEQ_start,
    input  logic [31:0]      fAPBS_SEQ_wdata,
    input  logic             fAPBS_SEQ_wvalid,
    output logic             SEQ_APBS_wready,
    input  logic [0:31]      CCFF_TAIL,
    output logic [0:31]      SEQ_CCFF_HEAD,
    output logic             SEQ_CCFF_SHIFT_EN,
    output logic [31:0]      SEQ_CHKS_wdata,
    output logic             SEQ_CHKS_fprechksum_w0_en,
    output logic             SEQ_CHKS_fprechksum_w1_en,
    output logic             SEQ_CHKS_fpostchksum_w0_en,
    output logic             SEQ_CHKS_fpostchksum_w1_en,
    output logic             SEQ_CHKS_win_postchs_rdata,
    output logic             SEQ_CSR_busy,
    output logic             SEQ_CSR_done,
    output logic             SEQ_CSR_abort,
    output logic [CNT_W-1:0] SEQ_CSR_wcnt
);

`ifdef FCB_CFG_SEQ_RB_RESTORE_EN
    localparam bit RbRestore = 1'b1;
`else
    localparam bit RbRestore = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(CHAIN_LEN - 1);
    localparam logic [1:0]       CmdPgm  = 2'd1;
    localparam logic [1:0]       CmdRb   = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StPgmWait,
        StPgmW0,
        StPgmW1,
        StRb,
        StRbDrain1,
        StRbDrain2
    } state_t;

    state_t           state_q;
    logic [1:0]       cmd_q;
    logic             wready_q;
    logic [0:31]      head_q;
    logic             shift_q;
    logic [31:0]      wdata_q;
    logic             pre_w0_q;
    logic             pre_w1_q;
    logic             post_w0_q;
    logic             post_w1_q;
    logic             win_q;
    logic             done_q;
    logic             abort_q;
    logic [CNT_W-1:0] wcnt_q;
    logic             rb_odd_q;
    logic [CNT_W-1:0] rb_idx_q;
    logic             busy;
    logic             abort_req;

    // Word bit k drives chain lane k.
    function automatic logic [0:31] to_lanes(input logic [31:0] w);
        logic [0:31] r;
        for (int k = 0; k < 32; k++) begin
            r[k] = w[k];
        end
        return r;
    endfunction

    assign busy      = (state_q != StIdle);
    // The command latched at start must stay put; any change (including idle) aborts.
    assign abort_req = busy && (CSR_SEQ_cfgcmd != cmd_q);

    always_ff @(posedge FCB_CLK or negedge fcb_reg_rstn) begin
        if (!fcb_reg_rstn) begin
            state_q   <= StIdle;
            cmd_q     <= 2'd0;
            wready_q  <= 1'b0;
            head_q    <= '0;
            shift_q   <= 1'b0;
            wdata_q   <= '0;
            pre_w0_q  <= 1'b0;
            pre_w1_q  <= 1'b0;
            post_w0_q <= 1'b0;
            post_w1_q <= 1'b0;
            win_q     <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            wcnt_q    <= '0;
            rb_odd_q  <= 1'b0;
            rb_idx_q  <= '0;
        end else if (abort_req) begin
            state_q   <= StIdle;
            wready_q  <= 1'b0;
            head_q    <= '0;
            shift_q   <= 1'b0;
            pre_w0_q  <= 1'b0;
            pre_w1_q  <= 1'b0;
            post_w0_q <= 1'b0;
            post_w1_q <= 1'b0;
            win_q     <= 1'b0;
            rb_odd_q  <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b1;
        end else begin
            shift_q   <= 1'b0;
            head_q    <= '0;
            pre_w0_q  <= 1'b0;
            pre_w1_q  <= 1'b0;
            win_q     <= 1'b0;
            post_w0_q <= 1'b0;
            post_w1_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (CSR_SEQ_start && (CSR_SEQ_cfgcmd == CmdPgm)) begin
                        state_q  <= StPgmWait;
                        cmd_q    <= CSR_SEQ_cfgcmd;
                        wready_q <= 1'b1;
                        wcnt_q   <= '0;
                        done_q   <= 1'b0;
                        abort_q  <= 1'b0;
                    end else if (CSR_SEQ_start && (CSR_SEQ_cfgcmd == CmdRb)) begin
                        state_q  <= StRb;
                        cmd_q    <= CSR_SEQ_cfgcmd;
                        rb_odd_q <= 1'b0;
                        rb_idx_q <= '0;
                        wcnt_q   <= '0;
                        done_q   <= 1'b0;
                        abort_q  <= 1'b0;
                    end
                end
                StPgmWait: begin
                    if (fAPBS_SEQ_wvalid) begin
                        state_q  <= StPgmW0;
                        wdata_q  <= fAPBS_SEQ_wdata;
                        head_q   <= to_lanes(fAPBS_SEQ_wdata);
                        shift_q  <= 1'b1;
                        pre_w0_q <= 1'b1;
                        wready_q <= 1'b0;
                    end
                end
                StPgmW0: begin
                    state_q  <= StPgmW1;
                    pre_w1_q <= 1'b1;
                    wcnt_q   <= wcnt_q + CNT_W'(1);
                    wready_q <= (wcnt_q != LastIdx);
                end
                StPgmW1: begin
                    if (!wready_q) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end else if (fAPBS_SEQ_wvalid) begin
                        state_q  <= StPgmW0;
                        wdata_q  <= fAPBS_SEQ_wdata;
                        head_q   <= to_lanes(fAPBS_SEQ_wdata);
                        shift_q  <= 1'b1;
                        pre_w0_q <= 1'b1;
                        wready_q <= 1'b0;
                    end else begin
                        state_q <= StPgmWait;
                    end
                end
                StRb: begin
                    // Even cycle: word becomes valid on the tail; odd cycle: window plus shift.
                    if (!rb_odd_q) begin
                        rb_odd_q <= 1'b1;
                        win_q    <= 1'b1;
                        shift_q  <= RbRestore || (rb_idx_q != LastIdx);
                    end else begin
                        rb_odd_q <= 1'b0;
                        rb_idx_q <= rb_idx_q + CNT_W'(1);
                        if (rb_idx_q == LastIdx) begin
                            state_q <= StRbDrain1;
                        end
                    end
                end
                StRbDrain1: begin
                    state_q <= StRbDrain2;
                end
                StRbDrain2: begin
                    state_q <= StIdle;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            // Post-sum enables trail the read window to match the checksum read-data delay.
            if ((state_q == StRb) || (state_q == StRbDrain1) || (state_q == StRbDrain2)) begin
                post_w0_q <= win_q;
                post_w1_q <= post_w0_q;
                if (post_w0_q) begin
                    wcnt_q <= wcnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign SEQ_CCFF_HEAD              = (RbRestore && (state_q == StRb)) ? CCFF_TAIL : head_q;
    assign SEQ_APBS_wready            = wready_q;
    assign SEQ_CCFF_SHIFT_EN          = shift_q;
    assign SEQ_CHKS_wdata             = wdata_q;
    assign SEQ_CHKS_fprechksum_w0_en  = pre_w0_q;
    assign SEQ_CHKS_fprechksum_w1_en  = pre_w1_q;
    assign SEQ_CHKS_fpostchksum_w0_en = post_w0_q;
    assign SEQ_CHKS_fpostchksum_w1_en = post_w1_q;
    assign SEQ_CHKS_win_postchs_rdata = win_q;
    assign SEQ_CSR_busy               = busy;
    assign SEQ_CSR_done               = done_q;
    assign SEQ_CSR_abort              = abort_q;
    assign SEQ_CSR_wcnt               = wcnt_q;

endmodule
